// File: rtl/button_event_gen.sv
// Button event generator: turns a debounced level into press,
// auto-repeat and release pulses for the game input logic.
module button_event_gen #(
   parameter int unsigned DELAY_CYCLES = 25_000_000,
   parameter int unsigned RATE_CYCLES  = 10_000_000,
   parameter int unsigned CNT_W        = 25
) (
   input  logic clk,
   input  logic reset,
   input  logic db_level,
   input  logic rpt_en,
   output logic press_tick,
   output logic repeat_tick,
   output logic release_tick,
   output logic fire,
   output logic held
);

   // WAIT_REL keeps a button held through reset from
   // ever producing a press.
   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      IDLE     = 2'd1,
      DELAY    = 2'd2,
      REPEAT   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DLY_TC = CNT_W'(DELAY_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_TC = CNT_W'(RATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             rpt_q, rpt_d;
   logic             rel_q, rel_d;
   logic             fire_q, fire_d;

   // State, counter and registered tick outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_REL;
         cnt_q   <= '0;
         press_q <= 1'b0;
         rpt_q   <= 1'b0;
         rel_q   <= 1'b0;
         fire_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         press_q <= press_d;
         rpt_q   <= rpt_d;
         rel_q   <= rel_d;
         fire_q  <= fire_d;
      end
   end

   // Next state, counter and tick decisions; release is checked
   // first so it always wins over a terminal-count repeat.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      rpt_d   = 1'b0;
      rel_d   = 1'b0;
      fire_d  = 1'b0;
      unique case (state_q)
         WAIT_REL: begin
            cnt_d = '0;
            if (!db_level) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            cnt_d = '0;
            if (db_level) begin
               press_d = 1'b1;
               fire_d  = 1'b1;
               state_d = DELAY;
            end
         end
         DELAY: begin
            if (!db_level) begin
               rel_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (!rpt_en) begin
               cnt_d = '0;
            end else if (cnt_q == DLY_TC) begin
               rpt_d   = 1'b1;
               fire_d  = 1'b1;
               cnt_d   = '0;
               state_d = REPEAT;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         REPEAT: begin
            if (!db_level) begin
               rel_d   = 1'b1;
               cnt_d   = '0;
               state_d = IDLE;
            end else if (!rpt_en) begin
               cnt_d   = '0;
               state_d = DELAY;
            end else if (cnt_q == RPT_TC) begin
               rpt_d  = 1'b1;
               fire_d = 1'b1;
               cnt_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = WAIT_REL;
            cnt_d   = '0;
         end
      endcase
   end

   assign press_tick   = press_q;
   assign repeat_tick  = rpt_q;
   assign release_tick = rel_q;
   assign fire         = fire_q;
   assign held         = (state_q == DELAY) || (state_q == REPEAT);

endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
- Sits downstream of the button debouncer and consumes one debounced, synchronous level.
- Converts the level into single-cycle game-input events: press, auto-repeat (typematic) and release.
- Player-movement and bomb-drop logic use these events, so a held direction key steps the player at a fixed rate.
- One instance per button. Counts are in clk cycles; defaults assume the 100 MHz system clock.

Parameters:
DELAY_CYCLES, 25_000_000, cycles from press_tick to first repeat_tick (250 ms); legal range >= 2
RATE_CYCLES, 10_000_000, cycles between consecutive repeat_ticks (100 ms); legal range >= 2
CNT_W, 25, counter width; must hold max(DELAY_CYCLES, RATE_CYCLES)-1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
db_level  input  1  debounced button level, already synchronous to clk, 1 = pressed
rpt_en  input  1  auto-repeat enable, 1 = repeat while held
press_tick  output  1  one-cycle pulse on press
repeat_tick  output  1  one-cycle pulse per repeat interval while held
release_tick  output  1  one-cycle pulse on release
fire  output  1  press_tick OR repeat_tick (registered, same cycle as those pulses)
held  output  1  1 while state is DELAY or REPEAT

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0, counter 0, state WAIT_REL. Reset mid-operation aborts any press with no release_tick.
- Outputs are registered. Every tick is 1 when the state logic at edge k decides the event, and 0 at edge k+1 unless re-decided.
- States and transitions, evaluated at each clk edge:
  - WAIT_REL: go to IDLE when db_level=0. No ticks. A button held through reset never produces press_tick.
  - IDLE: if db_level=1, set press_tick=1, fire=1, counter=0, go to DELAY.
  - DELAY:
    - If db_level=0: release_tick=1, counter=0, go to IDLE.
    - Else if rpt_en=0: counter held at 0.
    - Else if counter==DELAY_CYCLES-1: repeat_tick=1, fire=1, counter=0, go to REPEAT.
    - Else counter+1.
  - REPEAT:
    - If db_level=0: release_tick=1, counter=0, go to IDLE.
    - Else if rpt_en=0: counter=0, go to DELAY.
    - Else if counter==RATE_CYCLES-1: repeat_tick=1, fire=1, counter=0.
    - Else counter+1.
- Latency:
  - press_tick is high in the cycle after the first edge that samples db_level=1 in IDLE.
  - With rpt_en=1 throughout, the first repeat_tick comes exactly DELAY_CYCLES cycles after press_tick.
  - Subsequent repeat_ticks come every RATE_CYCLES cycles.
  - release_tick is 1 cycle after the edge that samples db_level=0.
- Priority: release beats repeat when db_level falls on the terminal-count edge (release_tick=1, repeat_tick=0). At most one of press/repeat/release is high in any cycle.
- Re-enable: rpt_en rising while held restarts the full DELAY_CYCLES wait.
- Re-press: a one-cycle release followed by a re-press gives release_tick then press_tick on consecutive cycles. The counter does not carry over between presses.
- Counter: unsigned CNT_W bits. It never exceeds the active terminal value and never wraps.
- held: combinational from registered state; 1 in DELAY and REPEAT only.

Test Plan:
1. Use DELAY=8, RATE=4. Reset with db_level=0, then db_level=1 at edge 10 and hold -> press_tick high cycle 11; repeat_tick cycles 19, 23, 27; held=1 from cycle 11.
2. Same parameters. Drop db_level on the edge where the repeat counter hits 3 -> release_tick=1, repeat_tick=0 that cycle; IDLE, held=0 next cycle.
3. Hold db_level=1 through reset and release reset -> no ticks. Drop db_level, then raise it -> exactly one press_tick.
4. Hold the button with rpt_en=0 for 50 cycles -> only press_tick. Raise rpt_en at cycle t -> first repeat_tick at t+8, then every 4.
5. Hold the button and assert reset while in REPEAT -> all outputs 0 next cycle, no release_tick. With db_level still 1, no press_tick until it goes 0 then 1.
6. Pulse db_level 1 for a single cycle -> press_tick, then release_tick the next cycle; fire equals press_tick; no repeat_tick.
